qsfp_xcvr_reset_seq: RTL and testbench
======================================

Name: qsfp_xcvr_reset_seq

Overview:
- Reset sequencer sitting directly upstream of the S10 H-tile native PHY channel in the QSFP transceiver test design.
- Drives tx/rx analogreset and tx/rx digitalreset in the H-tile-required order.
- Uses the PHY's *_stat acknowledge outputs, tx/rx_cal_busy, rx_is_lockedtodata and an external TX PLL lock.
- Reports tx_ready/rx_ready to the user logic.

Parameters:
- SYNC_STAGES, 2, flops per input synchronizer (min 2).
- TX_DIG_DELAY, 64, clk cycles digitalreset is held after analogreset_stat deasserts.
- RX_LTD_STABLE, 1000, consecutive clk cycles rx_is_lockedtodata must be high before rx digital release.
- RX_LOCK_TIMEOUT, 1000000, clk cycles in RX_LOCK before restarting the RX analog reset.
- CNT_W, 20, counter width; must hold max(TX_DIG_DELAY, RX_LTD_STABLE, RX_LOCK_TIMEOUT).

Ports:
- clk  in  1  free-running reset/reconfig clock
- reset_n  in  1  asynchronous active-low reset
- sw_reset  in  1  synchronous soft reset pulse; restarts both FSMs
- pll_locked  in  1  TX fPLL/ATX lock, asynchronous
- tx_cal_busy  in  1  from PHY, asynchronous
- rx_cal_busy  in  1  from PHY, asynchronous
- tx_analogreset_stat  in  1  from PHY, asynchronous
- tx_digitalreset_stat  in  1  from PHY, asynchronous
- rx_analogreset_stat  in  1  from PHY, asynchronous
- rx_digitalreset_stat  in  1  from PHY, asynchronous
- rx_is_lockedtodata  in  1  from PHY, asynchronous
- tx_analogreset  out  1  to PHY
- tx_digitalreset  out  1  to PHY
- rx_analogreset  out  1  to PHY
- rx_digitalreset  out  1  to PHY
- tx_ready  out  1  TX datapath usable
- rx_ready  out  1  RX datapath usable

Behaviour:
- Reset values: all four PHY reset outputs = 1; tx_ready = 0; rx_ready = 0; both FSMs in the *_ARST state; counters = 0.
- Input synchronization:
  - Every asynchronous input passes through SYNC_STAGES flops before use.
  - The FSM reacts SYNC_STAGES+1 cycles after an input edge.
- All outputs are registered. Independent TX and RX FSMs.

TX FSM:
- TX_ARST:
  - Both TX resets = 1.
  - Exit to TX_AWAIT when tx_analogreset_stat = 1, pll_locked = 1 and tx_cal_busy = 0.
  - tx_analogreset drops on entry to TX_AWAIT.
- TX_AWAIT: exit to TX_DHOLD when tx_analogreset_stat = 0; counter cleared on entry.
- TX_DHOLD: count to TX_DIG_DELAY-1, then go to TX_DWAIT with tx_digitalreset = 0.
- TX_DWAIT: go to TX_READY when tx_digitalreset_stat = 0; tx_ready = 1 registered on entry.
- Any TX state except TX_ARST: pll_locked = 0 forces TX_ARST next cycle, reasserting both resets and clearing tx_ready.

RX FSM:
- RX_ARST: both RX resets = 1; exit to RX_AWAIT when rx_analogreset_stat = 1 and rx_cal_busy = 0.
- RX_AWAIT: rx_analogreset = 0; go to RX_LOCK when rx_analogreset_stat = 0; both counters cleared.
- RX_LOCK:
  - Stability counter increments while lockedtodata = 1 and clears on any 0.
  - On reaching RX_LTD_STABLE-1, go to RX_DWAIT with rx_digitalreset = 0.
  - The timeout counter runs throughout RX_LOCK. On reaching RX_LOCK_TIMEOUT-1, go to RX_ARST.
  - If stability and timeout expire in the same cycle, stability wins.
- RX_DWAIT: go to RX_READY when rx_digitalreset_stat = 0; rx_ready = 1.

Common rules:
- sw_reset = 1, or reset_n asserted mid-sequence: both FSMs return to *_ARST with reset values. reset_n takes effect immediately; sw_reset takes effect next edge.
- Simultaneous sw_reset and an exit condition: sw_reset wins.
- tx_cal_busy or rx_cal_busy rising after *_ARST is ignored; recalibration is handled through sw_reset.

Optional Feature:
- Macro: QSFP_RST_SEQ_RX_LOL_RECOVER_EN.
- Defined:
  - In RX_READY or RX_DWAIT, synchronized rx_is_lockedtodata = 0 forces rx_digitalreset = 1 and rx_ready = 0 next cycle.
  - The FSM re-enters RX_LOCK with counters cleared; analog reset is not re-run.
- Undefined: loss of lock is ignored once in RX_DWAIT/RX_READY; rx_ready stays 1 until sw_reset or reset_n.

Decomposition:
- Package qsfp_xcvr_reset_pkg holds:
  - tx_state_t enum: TX_ARST, TX_AWAIT, TX_DHOLD, TX_DWAIT, TX_READY.
  - rx_state_t enum: RX_ARST, RX_AWAIT, RX_LOCK, RX_DWAIT, RX_READY.
  - Default parameter constants.
- One sub-module: qsfp_xcvr_bit_sync, a SYNC_STAGES-deep single-bit synchronizer with async active-low reset, instantiated per input.
- Reset value per instance is a parameter:
  - Value 1 for the *_stat and *_cal_busy inputs.
  - Value 0 for pll_locked and rx_is_lockedtodata.

Test Plan:
- Normal TX bring-up:
  - Stimulus: reset_n released; PHY model echoes each reset to its stat after 10 cycles; pll_locked = 1; cal_busy = 0.
  - Required: tx_analogreset falls first; tx_digitalreset falls exactly 64 cycles after tx_analogreset_stat sync fall; tx_ready = 1 after tx_digitalreset_stat falls.
- PLL loss:
  - Stimulus: pll_locked = 0 for 1 cycle (held past sync) while in TX_READY.
  - Required: tx_ready = 0 and both TX resets = 1 within SYNC_STAGES+2 cycles; full sequence re-runs.
- RX timeout:
  - Stimulus: rx_is_lockedtodata held 0 with RX_LOCK_TIMEOUT = 100.
  - Required: rx_analogreset reasserted 100 cycles after RX_LOCK entry; repeats periodically.
- RX stability glitch:
  - Stimulus: lockedtodata high 999 cycles, low 1, high.
  - Required: rx_digitalreset released 1000 cycles after the glitch, not before.
- Soft reset:
  - Stimulus: sw_reset pulse during TX_DHOLD and RX_LOCK.
  - Required: all four resets = 1 and both readies = 0 next cycle; both sequences restart cleanly.
- Loss of lock in RX_READY:
  - Stimulus: rx_is_lockedtodata dropped while in RX_READY.
  - Required with macro: rx_ready = 0, rx_digitalreset = 1, rx_analogreset stays 0.
  - Required without macro: rx_ready stays 1.

Source files
------------

// File: rtl/qsfp_xcvr_reset_pkg.sv
//==============================================================================
// Package : qsfp_xcvr_reset_pkg
// Brief   : State encodings and default constants for the QSFP H-tile reset
//           sequencer.
// Rev     : 1.0 - initial release
//==============================================================================
`default_nettype none

package qsfp_xcvr_reset_pkg;

    typedef enum logic [2:0] {
        TX_ARST  = 3'd0,
        TX_AWAIT = 3'd1,
        TX_DHOLD = 3'd2,
        TX_DWAIT = 3'd3,
        TX_READY = 3'd4
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_ARST  = 3'd0,
        RX_AWAIT = 3'd1,
        RX_LOCK  = 3'd2,
        RX_DWAIT = 3'd3,
        RX_READY = 3'd4
    } rx_state_t;

    localparam int c_def_sync_stages     = 2;
    localparam int c_def_tx_dig_delay    = 64;
    localparam int c_def_rx_ltd_stable   = 1000;
    localparam int c_def_rx_lock_timeout = 1000000;
    localparam int c_def_cnt_w           = 20;

    // Synchronized inputs, LSB first: pll_locked, tx_cal_busy, rx_cal_busy,
    // tx_analogreset_stat, tx_digitalreset_stat, rx_analogreset_stat,
    // rx_digitalreset_stat, rx_is_lockedtodata.
    localparam int               c_num_sync = 8;
    localparam logic [7:0]       c_sync_rst = 8'b0111_1110;

endpackage

`default_nettype wire

// File: rtl/qsfp_xcvr_bit_sync.sv
//==============================================================================
// Module : qsfp_xcvr_bit_sync
// Brief  : SYNC_STAGES-deep single-bit synchronizer, async active-low reset to
//          RESET_VAL.
// Rev    : 1.0 - initial release
//==============================================================================
`default_nettype none

module qsfp_xcvr_bit_sync #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_d,
    output logic o_q
);

    logic [SYNC_STAGES-1:0] r_chain;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_chain <= {SYNC_STAGES{RESET_VAL}};
        end else begin
            r_chain <= {r_chain[SYNC_STAGES-2:0], i_d};
        end
    end

    assign o_q = r_chain[SYNC_STAGES-1];

endmodule

`default_nettype wire

// File: rtl/qsfp_xcvr_reset_seq.sv
//==============================================================================
// Module : qsfp_xcvr_reset_seq
// Brief  : TX/RX reset sequencer for the S10 H-tile native PHY channel.
//          Optional: QSFP_RST_SEQ_RX_LOL_RECOVER_EN re-enters RX_LOCK on loss
//          of lock in RX_DWAIT/RX_READY.
// Rev    : 1.0 - initial release
//==============================================================================
`default_nettype none

module qsfp_xcvr_reset_seq
    import qsfp_xcvr_reset_pkg::*;
#(
    parameter int SYNC_STAGES     = c_def_sync_stages,
    parameter int TX_DIG_DELAY    = c_def_tx_dig_delay,
    parameter int RX_LTD_STABLE   = c_def_rx_ltd_stable,
    parameter int RX_LOCK_TIMEOUT = c_def_rx_lock_timeout,
    parameter int CNT_W           = c_def_cnt_w
) (
    input  logic clk,
    input  logic reset_n,
    input  logic sw_reset,
    input  logic pll_locked,
    input  logic tx_cal_busy,
    input  logic rx_cal_busy,
    input  logic tx_analogreset_stat,
    input  logic tx_digitalreset_stat,
    input  logic rx_analogreset_stat,
    input  logic rx_digitalreset_stat,
    input  logic rx_is_lockedtodata,
    output logic tx_analogreset,
    output logic tx_digitalreset,
    output logic rx_analogreset,
    output logic rx_digitalreset,
    output logic tx_ready,
    output logic rx_ready
);

    localparam logic [CNT_W-1:0] c_tx_last  = CNT_W'(TX_DIG_DELAY - 1);
    localparam logic [CNT_W-1:0] c_stb_last = CNT_W'(RX_LTD_STABLE - 1);
    localparam logic [CNT_W-1:0] c_tmo_last = CNT_W'(RX_LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] c_one      = CNT_W'(1);

    logic [c_num_sync-1:0] w_async_in;
    logic [c_num_sync-1:0] w_sync;

    assign w_async_in = {rx_is_lockedtodata, rx_digitalreset_stat,
                         rx_analogreset_stat, tx_digitalreset_stat,
                         tx_analogreset_stat, rx_cal_busy, tx_cal_busy,
                         pll_locked};

    generate
        for (genvar i = 0; i < c_num_sync; i++) begin : g_sync
            qsfp_xcvr_bit_sync #(
                .SYNC_STAGES (SYNC_STAGES),
                .RESET_VAL   (c_sync_rst[i])
            ) u_sync (
                .clk     (clk),
                .reset_n (reset_n),
                .i_d     (w_async_in[i]),
                .o_q     (w_sync[i])
            );
        end
    endgenerate

    logic w_pll_locked, w_tx_cal_busy, w_rx_cal_busy;
    logic w_tx_arst_stat, w_tx_drst_stat, w_rx_arst_stat, w_rx_drst_stat;
    logic w_ltd;

    assign {w_ltd, w_rx_drst_stat, w_rx_arst_stat, w_tx_drst_stat,
            w_tx_arst_stat, w_rx_cal_busy, w_tx_cal_busy, w_pll_locked} = w_sync;

    tx_state_t        r_tx_state;
    logic [CNT_W-1:0] r_tx_cnt;
    logic             r_tx_arst, r_tx_drst, r_tx_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tx_state <= TX_ARST;
            r_tx_cnt   <= '0;
            r_tx_arst  <= 1'b1;
            r_tx_drst  <= 1'b1;
            r_tx_ready <= 1'b0;
        end else if (sw_reset || (r_tx_state != TX_ARST && !w_pll_locked)) begin
            r_tx_state <= TX_ARST;
            r_tx_cnt   <= '0;
            r_tx_arst  <= 1'b1;
            r_tx_drst  <= 1'b1;
            r_tx_ready <= 1'b0;
        end else begin
            case (r_tx_state)
                TX_ARST: begin
                    if (w_tx_arst_stat && w_pll_locked && !w_tx_cal_busy) begin
                        r_tx_state <= TX_AWAIT;
                        r_tx_arst  <= 1'b0;
                        r_tx_cnt   <= '0;
                    end
                end
                TX_AWAIT: begin
                    if (!w_tx_arst_stat) begin
                        r_tx_state <= TX_DHOLD;
                        r_tx_cnt   <= '0;
                    end
                end
                TX_DHOLD: begin
                    if (r_tx_cnt == c_tx_last) begin
                        r_tx_state <= TX_DWAIT;
                        r_tx_drst  <= 1'b0;
                    end else begin
                        r_tx_cnt <= r_tx_cnt + c_one;
                    end
                end
                TX_DWAIT: begin
                    if (!w_tx_drst_stat) begin
                        r_tx_state <= TX_READY;
                        r_tx_ready <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    rx_state_t        r_rx_state;
    logic [CNT_W-1:0] r_rx_stb, r_rx_tmo;
    logic             r_rx_arst, r_rx_drst, r_rx_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rx_state <= RX_ARST;
            r_rx_stb   <= '0;
            r_rx_tmo   <= '0;
            r_rx_arst  <= 1'b1;
            r_rx_drst  <= 1'b1;
            r_rx_ready <= 1'b0;
        end else if (sw_reset) begin
            r_rx_state <= RX_ARST;
            r_rx_stb   <= '0;
            r_rx_tmo   <= '0;
            r_rx_arst  <= 1'b1;
            r_rx_drst  <= 1'b1;
            r_rx_ready <= 1'b0;
        end else begin
            case (r_rx_state)
                RX_ARST: begin
                    if (w_rx_arst_stat && !w_rx_cal_busy) begin
                        r_rx_state <= RX_AWAIT;
                        r_rx_arst  <= 1'b0;
                    end
                end
                RX_AWAIT: begin
                    if (!w_rx_arst_stat) begin
                        r_rx_state <= RX_LOCK;
                        r_rx_stb   <= '0;
                        r_rx_tmo   <= '0;
                    end
                end
                RX_LOCK: begin
                    // Stability is tested first so it wins a same-cycle tie.
                    if (w_ltd && r_rx_stb == c_stb_last) begin
                        r_rx_state <= RX_DWAIT;
                        r_rx_drst  <= 1'b0;
                    end else if (r_rx_tmo == c_tmo_last) begin
                        r_rx_state <= RX_ARST;
                        r_rx_arst  <= 1'b1;
                        r_rx_stb   <= '0;
                        r_rx_tmo   <= '0;
                    end else begin
                        r_rx_stb <= w_ltd ? r_rx_stb + c_one : '0;
                        r_rx_tmo <= r_rx_tmo + c_one;
                    end
                end
                RX_DWAIT: begin
`ifdef QSFP_RST_SEQ_RX_LOL_RECOVER_EN
                    if (!w_ltd) begin
                        r_rx_state <= RX_LOCK;
                        r_rx_drst  <= 1'b1;
                        r_rx_ready <= 1'b0;
                        r_rx_stb   <= '0;
                        r_rx_tmo   <= '0;
                    end else
`endif
                    if (!w_rx_drst_stat) begin
                        r_rx_state <= RX_READY;
                        r_rx_ready <= 1'b1;
                    end
                end
                RX_READY: begin
`ifdef QSFP_RST_SEQ_RX_LOL_RECOVER_EN
                    if (!w_ltd) begin
                        r_rx_state <= RX_LOCK;
                        r_rx_drst  <= 1'b1;
                        r_rx_ready <= 1'b0;
                        r_rx_stb   <= '0;
                        r_rx_tmo   <= '0;
                    end
`endif
                end
                default: ;
            endcase
        end
    end

    assign tx_analogreset  = r_tx_arst;
    assign tx_digitalreset = r_tx_drst;
    assign tx_ready        = r_tx_ready;
    assign rx_analogreset  = r_rx_arst;
    assign rx_digitalreset = r_rx_drst;
    assign rx_ready        = r_rx_ready;

endmodule

`default_nettype wire

// File: tb/tb_qsfp_xcvr_reset_seq.sv
//==============================================================================
// Module : tb_qsfp_xcvr_reset_seq
// Brief  : Directed self-checking bench for qsfp_xcvr_reset_seq with a PHY
//          model that echoes each reset to its *_stat after 10 cycles.
// Rev    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_qsfp_xcvr_reset_seq;

    localparam int c_sync = 2;
    localparam int c_txd  = 64;
    localparam int c_stb  = 40;
    localparam int c_tmo  = 100;
    localparam int c_phy  = 10;
    localparam int c_lockentry = c_phy + c_sync + 1;

    logic clk = 1'b0;
    logic reset_n, sw_reset, pll_locked, tx_cal_busy, rx_cal_busy, ltd;
    logic tx_analogreset, tx_digitalreset, rx_analogreset, rx_digitalreset;
    logic tx_ready, rx_ready;
    logic [c_phy-1:0] r_ta, r_td, r_ra, r_rd;
    logic tx_analogreset_stat, tx_digitalreset_stat;
    logic rx_analogreset_stat, rx_digitalreset_stat;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ta <= '1; r_td <= '1; r_ra <= '1; r_rd <= '1;
        end else begin
            r_ta <= {r_ta[c_phy-2:0], tx_analogreset};
            r_td <= {r_td[c_phy-2:0], tx_digitalreset};
            r_ra <= {r_ra[c_phy-2:0], rx_analogreset};
            r_rd <= {r_rd[c_phy-2:0], rx_digitalreset};
        end
    end
    assign tx_analogreset_stat  = r_ta[c_phy-1];
    assign tx_digitalreset_stat = r_td[c_phy-1];
    assign rx_analogreset_stat  = r_ra[c_phy-1];
    assign rx_digitalreset_stat = r_rd[c_phy-1];

    qsfp_xcvr_reset_seq #(
        .SYNC_STAGES     (c_sync),
        .TX_DIG_DELAY    (c_txd),
        .RX_LTD_STABLE   (c_stb),
        .RX_LOCK_TIMEOUT (c_tmo),
        .CNT_W           (20)
    ) dut (
        .clk                  (clk),
        .reset_n              (reset_n),
        .sw_reset             (sw_reset),
        .pll_locked           (pll_locked),
        .tx_cal_busy          (tx_cal_busy),
        .rx_cal_busy          (rx_cal_busy),
        .tx_analogreset_stat  (tx_analogreset_stat),
        .tx_digitalreset_stat (tx_digitalreset_stat),
        .rx_analogreset_stat  (rx_analogreset_stat),
        .rx_digitalreset_stat (rx_digitalreset_stat),
        .rx_is_lockedtodata   (ltd),
        .tx_analogreset       (tx_analogreset),
        .tx_digitalreset      (tx_digitalreset),
        .rx_analogreset       (rx_analogreset),
        .rx_digitalreset      (rx_digitalreset),
        .tx_ready             (tx_ready),
        .rx_ready             (rx_ready)
    );

    localparam int ID_TA = 0, ID_TD = 1, ID_RA = 2, ID_RD = 3;
    localparam int ID_TR = 4, ID_RR = 5, ID_TAS = 6;

    function automatic logic sig(input int w);
        case (w)
            ID_TA:   return tx_analogreset;
            ID_TD:   return tx_digitalreset;
            ID_RA:   return rx_analogreset;
            ID_RD:   return rx_digitalreset;
            ID_TR:   return tx_ready;
            ID_RR:   return rx_ready;
            ID_TAS:  return tx_analogreset_stat;
            default: return 1'bx;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_lvl(input int w, input logic lvl, input string tag, output int t);
        int n = 0;
        while (sig(w) !== lvl && n < 2000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        assert (sig(w) === lvl) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b (timeout)", tag, sig(w), lvl);
        end
        t = cyc;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    int t_a, t_s, t_d, t_r, t1, t2, t3, t4, p;

    initial begin
        reset_n = 1'b0; sw_reset = 1'b0; pll_locked = 1'b1;
        tx_cal_busy = 1'b1; rx_cal_busy = 1'b0; ltd = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_values", {tx_analogreset, tx_digitalreset, rx_analogreset,
                               rx_digitalreset, tx_ready, rx_ready}, 6'b111100);
        reset_n = 1'b1;

        // TX bring-up, held in TX_ARST while calibration is busy
        repeat (30) @(negedge clk);
        check("tx_cal_busy_hold", tx_analogreset, 1'b1);
        tx_cal_busy = 1'b0;
        wait_lvl(ID_TA, 1'b0, "tx_arst_fall", t_a);
        check("tx_order_dig_held", tx_digitalreset, 1'b1);
        wait_lvl(ID_TAS, 1'b0, "tx_arst_stat_fall", t_s);
        wait_lvl(ID_TD, 1'b0, "tx_drst_fall", t_d);
        check("tx_dig_delay", t_d - t_s, c_sync + 1 + c_txd);
        wait_lvl(ID_TR, 1'b1, "tx_ready_rise", t_r);
        check("tx_ready_latency", t_r - t_d, c_phy + c_sync + 1);

        // RX lock timeout: lockedtodata held low
        wait_lvl(ID_RA, 1'b1, "rx_arst_sync", t1);
        wait_lvl(ID_RA, 1'b0, "rx_arst_fall1", t1);
        wait_lvl(ID_RA, 1'b1, "rx_arst_rise1", t2);
        check("rx_timeout", t2 - t1, c_lockentry + c_tmo);
        wait_lvl(ID_RA, 1'b0, "rx_arst_fall2", t3);
        check("rx_rearm", t3 - t2, c_phy + c_sync + 1);
        wait_lvl(ID_RA, 1'b1, "rx_arst_rise2", t4);
        check("rx_timeout_repeat", t4 - t3, c_lockentry + c_tmo);

        // RX stability glitch: one low sample just as the count would complete
        wait_lvl(ID_RA, 1'b0, "rx_arst_fall3", t_a);
        ltd = 1'b1;
        wait_until(t_a + c_lockentry + c_stb - 1 - c_sync);
        ltd = 1'b0;
        @(negedge clk);
        ltd = 1'b1;
        wait_until(t_a + c_lockentry + c_stb - 1 - c_sync + c_sync + c_stb);
        check("rx_dig_before_stable", rx_digitalreset, 1'b1);
        @(negedge clk);
        check("rx_dig_release", rx_digitalreset, 1'b0);
        t_d = cyc;
        wait_lvl(ID_RR, 1'b1, "rx_ready_rise", t_r);
        check("rx_ready_latency", t_r - t_d, c_phy + c_sync + 1);

        // PLL loss while TX_READY
        p = cyc;
        pll_locked = 1'b0;
        @(negedge clk);
        pll_locked = 1'b1;
        wait_until(p + c_sync);
        check("pll_loss_not_early", tx_ready, 1'b1);
        @(negedge clk);
        check("pll_loss_tx", {tx_analogreset, tx_digitalreset, tx_ready}, 3'b110);
        check("pll_loss_rx_unaffected", rx_ready, 1'b1);
        wait_lvl(ID_TR, 1'b1, "pll_loss_rerun", t_r);

        // Soft reset, first from READY, then again during TX_DHOLD/RX_LOCK
        ltd = 1'b0;
        sw_reset = 1'b1;
        @(negedge clk);
        sw_reset = 1'b0;
        check("sw_reset_ready", {tx_analogreset, tx_digitalreset, rx_analogreset,
                                 rx_digitalreset, tx_ready, rx_ready}, 6'b111100);
        wait_lvl(ID_TA, 1'b0, "sw_restart_tx_arst", t_a);
        wait_until(t_a + c_lockentry + 20);
        check("sw_mid_state", {tx_analogreset, tx_digitalreset, rx_analogreset,
                               rx_digitalreset}, 4'b0101);
        sw_reset = 1'b1;
        @(negedge clk);
        sw_reset = 1'b0;
        check("sw_reset_mid", {tx_analogreset, tx_digitalreset, rx_analogreset,
                               rx_digitalreset, tx_ready, rx_ready}, 6'b111100);
        ltd = 1'b1;
        wait_lvl(ID_TR, 1'b1, "sw_restart_tx_ready", t_r);
        wait_lvl(ID_RR, 1'b1, "sw_restart_rx_ready", t_r);

        // Loss of lock while RX_READY
        p = cyc;
        ltd = 1'b0;
        wait_until(p + c_sync);
        check("lol_not_early", rx_ready, 1'b1);
        @(negedge clk);
`ifdef QSFP_RST_SEQ_RX_LOL_RECOVER_EN
        check("lol_recover", {rx_analogreset, rx_digitalreset, rx_ready}, 3'b010);
        ltd = 1'b1;
        wait_lvl(ID_RR, 1'b1, "lol_relock", t_r);
`else
        check("lol_ignored", {rx_analogreset, rx_digitalreset, rx_ready}, 3'b001);
        repeat (5) @(negedge clk);
        check("lol_ignored_hold", rx_ready, 1'b1);
`endif

        // Asynchronous reset mid-cycle takes effect without a clock edge
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1 check("async_reset", {tx_analogreset, tx_digitalreset, rx_analogreset,
                                 rx_digitalreset, tx_ready, rx_ready}, 6'b111100);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
